core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the core. Sequences one instruction at a time

---
 rtl/core_sequencer_if.sv | 25 ++
 rtl/core_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_core_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Request/grant handshake between the core sequencer (master) and the
// instruction/data memory side (slave).
interface core_sequencer_if;
  logic imem_req;
  logic imem_gnt;
  logic dmem_req;
  logic dmem_we;
  logic dmem_gnt;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_gnt,
    input  dmem_gnt
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_gnt,
    output dmem_gnt
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter and trap.
// Optional memory-grant watchdog is enabled by defining SEQ_MEM_TIMEOUT_EN.
module core_sequencer #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [6:0]           opcode_i,
  input  logic                 dec_reg_write_i,
  core_sequencer_if.master     mem_if,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 rf_we_o,
  output logic [2:0]           state_o,
  output logic                 trap_o,
  output logic [1:0]           trap_cause_o,
  output logic [CNT_W-1:0]     instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_e             state_q, state_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q;

  logic imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s, rf_we_s;
  logic is_load_s, is_store_s, is_branch_s, is_legal_s;
  logic tmo_hit_s;

  assign is_load_s   = (opcode_i == OP_LOAD);
  assign is_store_s  = (opcode_i == OP_STORE);
  assign is_branch_s = (opcode_i == OP_BRANCH);
  assign is_legal_s  = (opcode_i == OP_ALU)   || (opcode_i == OP_ALUI)  ||
                       is_load_s || is_store_s || is_branch_s ||
                       (opcode_i == OP_LUI)   || (opcode_i == OP_AUIPC) ||
                       (opcode_i == OP_JAL)   || (opcode_i == OP_JALR);

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  // Counts gnt-low cycles in FETCH/MEM; any other cycle leaves it at zero for the next entry.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_FETCH && !mem_if.imem_gnt) || (state_q == S_MEM && !mem_if.dmem_gnt)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // Watchdog compiled out: the limit can never be reached.
  assign tmo_hit_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and per-state strobe decode.
  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    rf_we_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (mem_if.imem_gnt) begin
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit_s) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_legal_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd0;
        end
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) begin
          state_d = S_MEM;
        end else if (is_branch_s) begin
          pc_we_s = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = is_store_s;
        if (mem_if.dmem_gnt) begin
          if (is_store_s) begin
            pc_we_s = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit_s) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s = dec_reg_write_i;
        pc_we_s = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = 2'd0;
      end
    endcase
  end

  // State, trap flags and retire counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_q + CNT_W'(pc_we_s);
    end
  end

  // Strobes are held low for the whole reset cycle so an abandoned access leaves no trace.
  assign mem_if.imem_req = rst_ni & imem_req_s;
  assign mem_if.dmem_req = rst_ni & dmem_req_s;
  assign mem_if.dmem_we  = rst_ni & dmem_we_s;
  assign ir_we_o         = rst_ni & ir_we_s;
  assign pc_we_o         = rst_ni & pc_we_s;
  assign rf_we_o         = rst_ni & rf_we_s;
  assign state_o         = state_q;
  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;
  assign instret_o       = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: expected per-cycle traces are built
// from the instruction class and randomized grant delays.
module tb_core_sequencer;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ILL    = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       dreq;
    logic       dwe;
    logic       irwe;
    logic       pcwe;
    logic       rfwe;
    logic       ig;
    logic       dg;
  } cyc_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       dec_reg_write;
  logic       ir_we, pc_we, rf_we, trap;
  logic [2:0] state;
  logic [1:0] trap_cause;
  logic [3:0] instret;
  logic [3:0] exp_instret;
  logic [6:0] legal_ops [9];

  int vectors;
  int miscompares;

  core_sequencer_if bus ();

  core_sequencer #(.CNT_W(4), .TIMEOUT_CYCLES(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .opcode_i        (opcode),
    .dec_reg_write_i (dec_reg_write),
    .mem_if          (bus.master),
    .ir_we_o         (ir_we),
    .pc_we_o         (pc_we),
    .rf_we_o         (rf_we),
    .state_o         (state),
    .trap_o          (trap),
    .trap_cause_o    (trap_cause),
    .instret_o       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit hit");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_gnt = 1'($urandom_range(0, 1));
    bus.dmem_gnt = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 4'd0;
  endtask

  // Runs one instruction from FETCH entry, checking every cycle and the retire count.
  task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input logic rw);
    cyc_t q[$];
    cyc_t c;
    cyc_t obs;
    cyc_t expv;
    bit ld;
    bit is_st;
    bit br;
    ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    br = (op == OP_BRANCH);
    for (int k = 0; k <= wi; k++) begin
      c = '0; c.st = 3'd0; c.ireq = 1'b1; c.ig = (k == wi); c.irwe = (k == wi);
      c.dg = 1'($urandom_range(0, 1));
      q.push_back(c);
    end
    c = '0; c.st = 3'd1; c.ig = 1'($urandom_range(0, 1)); c.dg = 1'($urandom_range(0, 1));
    q.push_back(c);
    c = '0; c.st = 3'd2; c.pcwe = br; c.ig = 1'($urandom_range(0, 1)); c.dg = 1'($urandom_range(0, 1));
    q.push_back(c);
    if (ld || is_st) begin
      for (int k = 0; k <= wd; k++) begin
        c = '0; c.st = 3'd3; c.dreq = 1'b1; c.dwe = is_st; c.dg = (k == wd);
        c.pcwe = is_st && (k == wd); c.ig = 1'($urandom_range(0, 1));
        q.push_back(c);
      end
    end
    if (!br && !is_st) begin
      c = '0; c.st = 3'd4; c.rfwe = rw; c.pcwe = 1'b1;
      c.ig = 1'($urandom_range(0, 1)); c.dg = 1'($urandom_range(0, 1));
      q.push_back(c);
    end
    foreach (q[i]) begin
      opcode = op;
      dec_reg_write = rw;
      bus.imem_gnt = q[i].ig;
      bus.dmem_gnt = q[i].dg;
      #1;
      expv = q[i];
      obs = {state, bus.imem_req, bus.dmem_req, bus.dmem_req & bus.dmem_we,
             ir_we, pc_we, rf_we, q[i].ig, q[i].dg};
      vectors++;
      if (obs !== expv || trap !== 1'b0) begin
        miscompares++;
        $display("FAIL instr_cycle op=%b cyc=%0d got=%b trap=%b exp=%b", op, i, obs, trap, expv);
      end
      @(negedge clk);
    end
    exp_instret = exp_instret + 4'd1;
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL instret op=%b got=%0d exp=%0d", op, instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_gnt = 1'b1;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, rf_we} !== 6'b0 ||
        state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0 || instret !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state got st=%0d trap=%b cause=%0d instret=%0d strobes=%b exp all zero",
               state, trap, trap_cause, instret,
               {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, rf_we});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 4'd0;
  endtask

  task automatic test_directed();
    run_instr(OP_ALU, 0, 0, 1'b1);
    run_instr(OP_LOAD, 0, 3, 1'b1);
    run_instr(OP_BRANCH, 0, 0, 1'b1);
    run_instr(OP_STORE, 0, 0, 1'b1);
    run_instr(OP_STORE, 2, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 17; n++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
    end
    vectors++;
    if (instret !== 4'd1) begin
      miscompares++;
      $display("FAIL instret_wrap got=%0d exp=1", instret);
    end
  endtask

  task automatic test_trap();
    do_reset();
    opcode = OP_ILL;
    bus.imem_gnt = 1'b1;
    bus.dmem_gnt = 1'b0;
    #1;
    vectors++;
    if (state !== 3'd0 || ir_we !== 1'b1) begin
      miscompares++;
      $display("FAIL trap_fetch got st=%0d ir_we=%b exp st=0 ir_we=1", state, ir_we);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (state !== 3'd1 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_decode got st=%0d trap=%b exp st=1 trap=0", state, trap);
    end
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      bus.imem_gnt = 1'($urandom_range(0, 1));
      bus.dmem_gnt = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd0 ||
          {bus.imem_req, bus.dmem_req, ir_we, pc_we, rf_we} !== 5'b0) begin
        miscompares++;
        $display("FAIL trap_hold k=%0d got st=%0d trap=%b cause=%0d exp st=7 trap=1 cause=0",
                 k, state, trap, trap_cause);
      end
      @(negedge clk);
    end
    do_reset();
    bus.imem_gnt = 1'b0;
    #1;
    vectors++;
    if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0 || instret !== 4'd0) begin
      miscompares++;
      $display("FAIL trap_clear got st=%0d trap=%b cause=%0d exp st=0 trap=0 cause=0",
               state, trap, trap_cause);
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    opcode = OP_LOAD;
    dec_reg_write = 1'b1;
    bus.imem_gnt = 1'b1;
    bus.dmem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #1;
    vectors++;
    if (state !== 3'd3 || bus.dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_mem_setup got st=%0d dmem_req=%b exp st=3 dmem_req=1", state, bus.dmem_req);
    end
    rst_n = 1'b0;
    bus.dmem_gnt = 1'b1;
    #1;
    vectors++;
    if ({bus.dmem_req, pc_we, rf_we, ir_we} !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_mem_reset_cycle got strobes=%b exp 0000", {bus.dmem_req, pc_we, rf_we, ir_we});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_gnt = 1'b0;
    #1;
    vectors++;
    if (state !== 3'd0 || bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b1 || instret !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_mem_after got st=%0d dmem_req=%b imem_req=%b exp st=0 dmem_req=0 imem_req=1",
               state, bus.dmem_req, bus.imem_req);
    end
    rst_n = 1'b0;
    bus.imem_gnt = 1'b1;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b0 || ir_we !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fetch_reset got imem_req=%b ir_we=%b exp 0 0", bus.imem_req, ir_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 4'd0;
    run_instr(OP_ALU, 1, 0, 1'b0);
  endtask

`ifdef SEQ_MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    opcode = OP_ALU;
    bus.imem_gnt = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      #1;
      vectors++;
      if (state !== 3'd0 || bus.imem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_wait k=%0d got st=%0d req=%b exp st=0 req=1", k, state, bus.imem_req);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd1 || bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_trap got st=%0d trap=%b cause=%0d exp st=7 trap=1 cause=1",
               state, trap, trap_cause);
    end
    do_reset();
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (state !== 3'd1 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_gnt_wins got st=%0d trap=%b exp st=1 trap=0", state, trap);
    end
    do_reset();
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_instret = 4'd0;
    legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
    legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b0110111;
    legal_ops[6] = 7'b0010111; legal_ops[7] = 7'b1101111; legal_ops[8] = 7'b1100111;
    rst_n = 1'b0;
    opcode = OP_ALU;
    dec_reg_write = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.dmem_gnt = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_wrap();
    test_trap();
    test_reset_mid_access();
`ifdef SEQ_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
